// File: rtl/arm_multicycle_ctrl_pkg.sv
// Shared encodings for the ARM-subset multi-cycle controller:
// FSM states, ALU ops, instruction fields and datapath select codes.
package arm_multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH
  } state_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_RAW = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  localparam logic [3:0] R_PC = 4'd15;

  function automatic logic cmd_ok(input logic [3:0] cmd);
    return cmd inside {CMD_AND, CMD_SUB, CMD_ADD, CMD_CMP, CMD_ORR};
  endfunction

  function automatic logic cmd_arith(input logic [3:0] cmd);
    return cmd inside {CMD_SUB, CMD_ADD, CMD_CMP};
  endfunction

  function automatic logic [1:0] alu_of(input logic [3:0] cmd);
    logic [1:0] r;
    r = ALU_ADD;
    unique case (1'b1)
      (cmd == CMD_SUB),
      (cmd == CMD_CMP): r = ALU_SUB;
      (cmd == CMD_AND): r = ALU_AND;
      (cmd == CMD_ORR): r = ALU_ORR;
      default:          r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/arm_multicycle_ctrl_cond_check.sv
// ARM condition-code evaluator: Cond field against stored NZCV.
// 4'b1111 (reserved) evaluates false.
module arm_multicycle_ctrl_cond_check (
  input  logic [3:0] Cond,
  input  logic [3:0] NZCV,
  output logic       CondEx
);

  logic w_n, w_z, w_c, w_v, w_ge;

  assign {w_n, w_z, w_c, w_v} = NZCV;
  assign w_ge = (w_n == w_v);

  always_comb begin
    CondEx = 1'b0;
    unique case (Cond)
      4'b0000: CondEx = w_z;
      4'b0001: CondEx = ~w_z;
      4'b0010: CondEx = w_c;
      4'b0011: CondEx = ~w_c;
      4'b0100: CondEx = w_n;
      4'b0101: CondEx = ~w_n;
      4'b0110: CondEx = w_v;
      4'b0111: CondEx = ~w_v;
      4'b1000: CondEx = w_c & ~w_z;
      4'b1001: CondEx = ~w_c | w_z;
      4'b1010: CondEx = w_ge;
      4'b1011: CondEx = ~w_ge;
      4'b1100: CondEx = ~w_z & w_ge;
      4'b1101: CondEx = w_z | ~w_ge;
      4'b1110: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_multicycle_ctrl.sv
// Multi-cycle Moore control unit with IR and NZCV flag register.
// Conditional execution and flags exist only with CTRL_COND_EXEC_EN.
module arm_multicycle_ctrl
  import arm_multicycle_ctrl_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] ReadData,
  input  logic [3:0]  ALUFlags,
  output logic [3:0]  A1,
  output logic [3:0]  A2,
  output logic [3:0]  A3,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUControl,
  output logic [31:0] Instr
);

  state_e      r_state;
  state_e      w_next;
  logic [31:0] r_ir;
  logic        w_cond_ex;

  logic [1:0] w_op;
  logic       w_i;
  logic [3:0] w_cmd;
  logic       w_s;
  logic [3:0] w_rn, w_rd, w_rm;
  logic       w_is_br, w_is_str;

  assign w_op  = r_ir[27:26];
  assign w_i   = r_ir[25];
  assign w_cmd = r_ir[24:21];
  assign w_s   = r_ir[20];
  assign w_rn  = r_ir[19:16];
  assign w_rd  = r_ir[15:12];
  assign w_rm  = r_ir[3:0];

  assign w_is_br  = (w_op == OP_BR);
  assign w_is_str = (w_op == OP_MEM) & ~w_s;

  assign A1    = w_is_br ? R_PC : w_rn;
  assign A2    = w_is_str ? w_rd : w_rm;
  assign A3    = w_rd;
  assign Instr = r_ir;

  logic       w_rw, w_mw, w_irw, w_pcw, w_adr, w_srca;
  logic [1:0] w_srcb, w_res, w_imm, w_alu;

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_ff @(posedge CLK) begin
    if (RESET)      r_ir <= '0;
    else if (w_irw) r_ir <= ReadData;
  end

  always_comb begin
    w_next = r_state;
    w_rw   = 1'b0;
    w_mw   = 1'b0;
    w_irw  = 1'b0;
    w_pcw  = 1'b0;
    w_adr  = 1'b0;
    w_srca = 1'b0;
    w_srcb = SRCB_REG;
    w_res  = RES_ALU;
    w_imm  = IMM_DP;
    w_alu  = ALU_ADD;
    unique case (r_state)
      S_FETCH: begin
        w_irw  = 1'b1;
        w_pcw  = 1'b1;
        w_srca = 1'b1;
        w_srcb = SRCB_FOUR;
        w_res  = RES_RAW;
        w_next = S_DECODE;
      end
      S_DECODE: begin
        w_srca = 1'b1;
        w_srcb = SRCB_FOUR;
        w_next = S_FETCH;
        if (w_cond_ex) begin
          unique case (1'b1)
            (w_op == OP_DP): begin
              if (cmd_ok(w_cmd))
                w_next = w_i ? S_EXECI : S_EXECR;
            end
            (w_op == OP_MEM): w_next = S_MEMADR;
            (w_op == OP_BR):  w_next = S_BRANCH;
            default:          w_next = S_FETCH;
          endcase
        end
      end
      S_EXECR, S_EXECI: begin
        if (r_state == S_EXECI) begin
          w_srcb = SRCB_IMM;
          w_imm  = IMM_DP;
        end
        w_alu  = alu_of(w_cmd);
        w_next = (w_cmd == CMD_CMP) ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        w_res  = RES_ALU;
        w_rw   = (w_rd != R_PC);
        w_pcw  = (w_rd == R_PC);
        w_next = S_FETCH;
      end
      S_MEMADR: begin
        w_srcb = SRCB_IMM;
        w_imm  = IMM_MEM;
        w_alu  = ALU_ADD;
        w_next = w_s ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_adr  = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_res  = RES_MEM;
        w_rw   = (w_rd != R_PC);
        w_pcw  = (w_rd == R_PC);
        w_next = S_FETCH;
      end
      S_MEMWR: begin
        w_adr  = 1'b1;
        w_mw   = 1'b1;
        w_next = S_FETCH;
      end
      S_BRANCH: begin
        w_imm  = IMM_BR;
        w_srca = 1'b0;
        w_srcb = SRCB_IMM;
        w_res  = RES_RAW;
        w_pcw  = 1'b1;
        w_next = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // RESET masks every strobe so nothing commits in the reset cycle.
  assign RegWrite   = w_rw   & ~RESET;
  assign MemWrite   = w_mw   & ~RESET;
  assign IRWrite    = w_irw  & ~RESET;
  assign PCWrite    = w_pcw  & ~RESET;
  assign AdrSrc     = w_adr  & ~RESET;
  assign ALUSrcA    = w_srca & ~RESET;
  assign ALUSrcB    = RESET ? 2'b00 : w_srcb;
  assign ResultSrc  = RESET ? 2'b00 : w_res;
  assign ImmSrc     = RESET ? 2'b00 : w_imm;
  assign ALUControl = RESET ? 2'b00 : w_alu;

`ifdef CTRL_COND_EXEC_EN
  logic [3:0] r_flags;
  logic       w_flag_we;

  assign w_flag_we = ((r_state == S_EXECR) | (r_state == S_EXECI)) & w_s;

  // N/Z always follow the ALU; C/V only for arithmetic ops.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_flags <= '0;
    end else if (w_flag_we) begin
      r_flags[3:2] <= ALUFlags[3:2];
      if (cmd_arith(w_cmd))
        r_flags[1:0] <= ALUFlags[1:0];
    end
  end

  arm_multicycle_ctrl_cond_check u_cond_check (
    .Cond   (r_ir[31:28]),
    .NZCV   (r_flags),
    .CondEx (w_cond_ex)
  );
`else
  logic w_unused;

  assign w_cond_ex = 1'b1;
  assign w_unused  = ^ALUFlags;
`endif

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Directed vector bench for arm_multicycle_ctrl.
// Expectations adapt to CTRL_COND_EXEC_EN where flags change behaviour.
module tb_arm_multicycle_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] ReadData = '0;
  logic [3:0]  ALUFlags = '0;
  logic [3:0]  A1, A2, A3;
  logic        RegWrite, MemWrite, IRWrite, PCWrite, AdrSrc, ALUSrcA;
  logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, ALUControl;
  logic [31:0] Instr;

  arm_multicycle_ctrl dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .ReadData   (ReadData),
    .ALUFlags   (ALUFlags),
    .A1         (A1),
    .A2         (A2),
    .A3         (A3),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .Instr      (Instr)
  );

  always #5 CLK = ~CLK;

`ifdef CTRL_COND_EXEC_EN
  localparam int NT_CYC = 2;
  localparam int NT_PCW = 0;
`else
  localparam int NT_CYC = 3;
  localparam int NT_PCW = 1;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  flags;
    int          cyc;
    int          a1;
    int          a2;
    int          a3;
    int          rw;
    int          rw_at;
    int          mw;
    int          pcw;
    int          adr;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int strobes();
    return int'({RegWrite, MemWrite, IRWrite, PCWrite, AdrSrc, ALUSrcA,
                 ALUSrcB, ResultSrc, ImmSrc, ALUControl});
  endfunction

  // Entry: at a negedge inside the FETCH cycle of this instruction.
  // Exit: at the negedge inside the next instruction's FETCH cycle.
  task automatic run_instr(input vec_t v, input string tag);
    int idx, rw, rw_at, mw, pcw, adr;
    bit done;
    ReadData = v.instr;
    ALUFlags = v.flags;
    chk({tag, " fetch IRWrite"}, int'(IRWrite), 1);
    idx = 1; rw = 0; rw_at = 0; mw = 0; pcw = 0; adr = 0;
    done = 1'b0;
    while (!done && idx <= 12) begin
      if (RegWrite) begin rw++; rw_at = idx; end
      if (MemWrite) mw++;
      if (AdrSrc) adr++;
      if (PCWrite && idx > 1) pcw++;
      @(negedge CLK);
      idx++;
      if (idx == 2) begin
        chk({tag, " A1"}, int'(A1), v.a1);
        chk({tag, " A2"}, int'(A2), v.a2);
        chk({tag, " A3"}, int'(A3), v.a3);
      end
      if (IRWrite) done = 1'b1;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL %s timeout: no next FETCH within 12 cycles", tag);
    end
    chk({tag, " cycles"}, idx - 1, v.cyc);
    chk({tag, " RegWrite count"}, rw, v.rw);
    chk({tag, " RegWrite cycle"}, rw_at, v.rw_at);
    chk({tag, " MemWrite count"}, mw, v.mw);
    chk({tag, " PCWrite count"}, pcw, v.pcw);
    chk({tag, " AdrSrc count"}, adr, v.adr);
  endtask

  initial begin
    vec_t cmpv, beqv;

    //              instr         flg      cyc    a1  a2  a3 rw @  mw pcw    adr
    vecs[0]  = '{32'hE0821003, 4'b0000, 4,      2,  3,  1, 1, 4, 0, 0,      0};
    vecs[1]  = '{32'hE5954008, 4'b0000, 5,      5,  8,  4, 1, 5, 0, 0,      1};
    vecs[2]  = '{32'hE5854008, 4'b0000, 4,      5,  4,  4, 0, 0, 1, 0,      1};
    vecs[3]  = '{32'hE1510001, 4'b0100, 3,      1,  1,  0, 0, 0, 0, 0,      0};
    vecs[4]  = '{32'h0A000002, 4'b0000, 3,      15, 2,  0, 0, 0, 0, 1,      0};
    vecs[5]  = '{32'hE2500001, 4'b0000, 4,      0,  1,  0, 1, 4, 0, 0,      0};
    vecs[6]  = '{32'h0A000002, 4'b0000, NT_CYC, 15, 2,  0, 0, 0, 0, NT_PCW, 0};
    vecs[7]  = '{32'hEC000000, 4'b0000, 2,      0,  0,  0, 0, 0, 0, 0,      0};
    vecs[8]  = '{32'hE0210003, 4'b0000, 2,      1,  3,  0, 0, 0, 0, 0,      0};
    vecs[9]  = '{32'hE082F003, 4'b0000, 4,      2,  3,  15, 0, 0, 0, 1,     0};
    vecs[10] = '{32'hE38670FF, 4'b0000, 4,      6,  15, 7, 1, 4, 0, 0,      0};
    vecs[11] = '{32'hE0122002, 4'b1010, 4,      2,  2,  2, 1, 4, 0, 0,      0};
    vecs[12] = '{32'h2A000002, 4'b0000, NT_CYC, 15, 2,  0, 0, 0, 0, NT_PCW, 0};
    vecs[13] = '{32'h4A000002, 4'b0000, 3,      15, 2,  0, 0, 0, 0, 1,      0};

    RESET = 1'b1;
    ReadData = vecs[0].instr;
    repeat (2) begin
      @(negedge CLK);
      chk("reset strobes", strobes(), 0);
      chk("reset A1A2A3", int'({A1, A2, A3}), 0);
      chk("reset Instr", int'(Instr), 0);
    end
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk("release PCWrite", int'(PCWrite), 1);

    for (int i = 0; i < NV; i++)
      run_instr(vecs[i], $sformatf("v%0d", i));

    // Set Z, then reset in the middle of a store.
    cmpv = vecs[3];
    run_instr(cmpv, "pre-reset CMP");
    ReadData = vecs[2].instr;
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    chk("MEMWR MemWrite", int'(MemWrite), 1);
    chk("MEMWR AdrSrc", int'(AdrSrc), 1);
    RESET = 1'b1;
    beqv = vecs[6];
    ReadData = beqv.instr;
    #1;
    chk("reset-cycle MemWrite", int'(MemWrite), 0);
    chk("reset-cycle RegWrite", int'(RegWrite), 0);
    @(negedge CLK);
    chk("in-reset strobes", strobes(), 0);
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk("post-reset PCWrite", int'(PCWrite), 1);
    run_instr(beqv, "post-reset BEQ");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
